// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush sequencer.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DMISS  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam int unsigned HALT_DRAIN_DEF = 3;
    localparam int unsigned CNT_W_DEF      = 16;

    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic ifid_flush;
        logic idex_wen;
        logic idex_nop;
        logic exmem_wen;
        logic memwb_wen;
    } ctrl_t;

    // Every write enable set to wen, no flush and no bubble.
    function automatic ctrl_t ctrl_all(input logic wen);
        ctrl_t c;
        c.pc_wen     = wen;
        c.ifid_wen   = wen;
        c.ifid_flush = 1'b0;
        c.idex_wen   = wen;
        c.idex_nop   = 1'b0;
        c.exmem_wen  = wen;
        c.memwb_wen  = wen;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bus: pipeline status in, stage enables and status out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_use_src1;
    logic             id_use_src2;
    logic             idex_memread;
    logic [3:0]       idex_dst;
    logic             branch_taken;
    logic             halt_id;
    logic             icache_miss;
    logic             dcache_miss;
    logic             pc_wen;
    logic             ifid_wen;
    logic             ifid_flush;
    logic             idex_wen;
    logic             idex_nop;
    logic             exmem_wen;
    logic             memwb_wen;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_src1, id_src2, id_use_src1, id_use_src2, idex_memread, idex_dst,
               branch_taken, halt_id, icache_miss, dcache_miss,
        input  pc_wen, ifid_wen, ifid_flush, idex_wen, idex_nop, exmem_wen, memwb_wen,
               halted, stall_cycles
    );

    modport slave (
        input  id_src1, id_src2, id_use_src1, id_use_src2, idex_memread, idex_dst,
               branch_taken, halt_id, icache_miss, dcache_miss,
        output pc_wen, ifid_wen, ifid_flush, idex_wen, idex_nop, exmem_wen, memwb_wen,
               halted, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use compare between the ID-stage sources and the load in EX; r0 never hazards.
module hazard_detect (
    input  logic       i_memread,
    input  logic [3:0] i_dst,
    input  logic [3:0] i_src1,
    input  logic [3:0] i_src2,
    input  logic       i_use_src1,
    input  logic       i_use_src2,
    output logic       o_load_use
);
    logic w_hit1;
    logic w_hit2;

    assign w_hit1     = i_use_src1 && (i_src1 == i_dst);
    assign w_hit2     = i_use_src2 && (i_src2 == i_dst);
    assign o_load_use = i_memread && (i_dst != 4'd0) && (w_hit1 || w_hit2);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: priority mux, FSM, drain and stall counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned HALT_DRAIN = HALT_DRAIN_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    pipeline_hazard_ctrl_if.slave  bus
);
    state_e           r_state;
    state_e           w_state_d;
    logic [7:0]       r_drain_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    ctrl_t            w_ctrl;
    logic             w_halted;
    logic             w_drain_load;
    logic             w_drain_dec;
    logic             w_load_use;

    hazard_detect u_hazard_detect (
        .i_memread  (bus.idex_memread),
        .i_dst      (bus.idex_dst),
        .i_src1     (bus.id_src1),
        .i_src2     (bus.id_src2),
        .i_use_src1 (bus.id_use_src1),
        .i_use_src2 (bus.id_use_src2),
        .o_load_use (w_load_use)
    );

    always_comb begin
        w_ctrl       = ctrl_all(1'b1);
        w_state_d    = r_state;
        w_halted     = 1'b0;
        w_drain_load = 1'b0;
        w_drain_dec  = 1'b0;
        case (r_state)
            RUN, DMISS: begin
                if (bus.dcache_miss) begin
                    w_ctrl    = ctrl_all(1'b0);
                    w_state_d = DMISS;
                end else begin
                    w_state_d = RUN;
                    if (w_load_use) begin
                        // Hold PC and IF/ID; branch/halt in ID are re-seen next cycle.
                        w_ctrl.pc_wen   = 1'b0;
                        w_ctrl.ifid_wen = 1'b0;
                        w_ctrl.idex_nop = 1'b1;
                    end else if (bus.halt_id) begin
                        w_ctrl.pc_wen     = 1'b0;
                        w_ctrl.ifid_flush = 1'b1;
                        w_drain_load      = 1'b1;
                        w_state_d         = DRAIN;
                    end else if (bus.branch_taken) begin
                        w_ctrl.ifid_flush = 1'b1;
                    end else if (bus.icache_miss) begin
                        w_ctrl.pc_wen     = 1'b0;
                        w_ctrl.ifid_flush = 1'b1;
                    end
                end
            end
            DRAIN: begin
                w_ctrl.pc_wen     = 1'b0;
                w_ctrl.ifid_flush = 1'b1;
                w_ctrl.idex_nop   = 1'b1;
                if (bus.dcache_miss) begin
                    w_ctrl.ifid_wen  = 1'b0;
                    w_ctrl.idex_wen  = 1'b0;
                    w_ctrl.exmem_wen = 1'b0;
                    w_ctrl.memwb_wen = 1'b0;
                end else begin
                    w_drain_dec = 1'b1;
                    // Halt retires when this decrement brings the count to 1.
                    if (r_drain_cnt <= 8'd2) begin
                        w_state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                w_ctrl   = ctrl_all(1'b0);
                w_halted = 1'b1;
            end
            default: begin
                w_state_d = RUN;
            end
        endcase
        if (i_rst) begin
            w_ctrl            = ctrl_all(1'b1);
            w_ctrl.ifid_flush = 1'b1;
            w_ctrl.idex_nop   = 1'b1;
            w_halted          = 1'b0;
            w_state_d         = RUN;
            w_drain_load      = 1'b0;
            w_drain_dec       = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= RUN;
            r_drain_cnt <= 8'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_drain_load) begin
                r_drain_cnt <= 8'(HALT_DRAIN);
            end else if (w_drain_dec) begin
                r_drain_cnt <= r_drain_cnt - 8'd1;
            end
            if (!w_ctrl.pc_wen && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.pc_wen       = w_ctrl.pc_wen;
    assign bus.ifid_wen     = w_ctrl.ifid_wen;
    assign bus.ifid_flush   = w_ctrl.ifid_flush;
    assign bus.idex_wen     = w_ctrl.idex_wen;
    assign bus.idex_nop     = w_ctrl.idex_nop;
    assign bus.exmem_wen    = w_ctrl.exmem_wen;
    assign bus.memwb_wen    = w_ctrl.memwb_wen;
    assign bus.halted       = w_halted;
    assign bus.stall_cycles = r_stall_cnt;
endmodule
